// File: rtl/llc_set_buf.sv
// LLC set buffer: one cache set held between SRAM read and write-back, with fill
// handshake, modified-since-load mask and victim search. Option: LLC_SET_BUF_WORD_WRITE_EN.
module llc_set_buf #(
  parameter int WAYS         = 16,
  parameter int LINE_BITS    = 128,
  parameter int WORDS        = 2,
  parameter int TAG_BITS     = 16,
  parameter int STATE_BITS   = 3,
  parameter int SHARERS_BITS = 16,
  parameter int OWNER_BITS   = 4,
  parameter int HPROT_BITS   = 1,
  localparam int WAY_BITS    = $clog2(WAYS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rst_state,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [WAYS*LINE_BITS-1:0]     ld_line,
  input  logic [WAYS*TAG_BITS-1:0]      ld_tag,
  input  logic [WAYS*STATE_BITS-1:0]    ld_state,
  input  logic [WAYS*SHARERS_BITS-1:0]  ld_sharers,
  input  logic [WAYS*OWNER_BITS-1:0]    ld_owner,
  input  logic [WAYS*HPROT_BITS-1:0]    ld_hprot,
  input  logic [WAYS-1:0]               ld_dirty,
  input  logic [WAY_BITS-1:0]           ld_evict_way,
  input  logic                          fill_valid,
  output logic                          fill_ready,
  input  logic [WAY_BITS-1:0]           fill_way,
  input  logic [LINE_BITS-1:0]          fill_line,
  input  logic [WAY_BITS-1:0]           wr_way,
  input  logic [6:0]                    wr_en,
  input  logic [WORDS-1:0]              wr_word_mask,
  input  logic [LINE_BITS-1:0]          wr_line,
  input  logic [TAG_BITS-1:0]           wr_tag,
  input  logic [STATE_BITS-1:0]         wr_state,
  input  logic [SHARERS_BITS-1:0]       wr_sharers,
  input  logic [OWNER_BITS-1:0]         wr_owner,
  input  logic [HPROT_BITS-1:0]         wr_hprot,
  input  logic                          wr_dirty,
  input  logic                          victim_req,
  output logic                          victim_valid,
  output logic [WAY_BITS-1:0]           victim_way,
  output logic                          victim_invalid,
  input  logic                          incr_evict,
  output logic [WAY_BITS-1:0]           evict_way,
  output logic [WAYS-1:0]               mod_mask,
  output logic [WAYS*LINE_BITS-1:0]     lines,
  output logic [WAYS*TAG_BITS-1:0]      tags,
  output logic [WAYS*STATE_BITS-1:0]    states,
  output logic [WAYS*SHARERS_BITS-1:0]  sharers,
  output logic [WAYS*OWNER_BITS-1:0]    owners,
  output logic [WAYS*HPROT_BITS-1:0]    hprots,
  output logic [WAYS-1:0]               dirty
);
  localparam int WORD_BITS = LINE_BITS / WORDS;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} fsm_t;

  fsm_t                    fsm_reg;
  logic [WAY_BITS-1:0]     k_reg;
  logic [WAY_BITS-1:0]     evict_reg;
  logic [WAY_BITS-1:0]     scan_way;
  logic                    load_hs;
  logic                    fill_hs;

  logic [LINE_BITS-1:0]    line_reg    [WAYS];
  logic [TAG_BITS-1:0]     tag_reg     [WAYS];
  logic [STATE_BITS-1:0]   state_reg   [WAYS];
  logic [SHARERS_BITS-1:0] sharers_reg [WAYS];
  logic [OWNER_BITS-1:0]   owner_reg   [WAYS];
  logic [HPROT_BITS-1:0]   hprot_reg   [WAYS];
  logic                    dirty_reg   [WAYS];
  logic                    mod_reg     [WAYS];

  assign load_ready = (fsm_reg == IDLE) && !rst_state;
  assign fill_ready = !rst_state;
  assign load_hs    = load_valid && load_ready;
  assign fill_hs    = fill_valid && fill_ready;
  assign evict_way  = evict_reg;
  assign scan_way   = evict_reg + k_reg;

`ifndef LLC_SET_BUF_WORD_WRITE_EN
  logic unused_mask;
  assign unused_mask = ^wr_word_mask;
`endif

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    logic                 fill_hit;
    logic                 wr_hit;
    logic [LINE_BITS-1:0] wr_merged;

    assign fill_hit = fill_hs && (fill_way == WAY_BITS'(gi));
    assign wr_hit   = (wr_way == WAY_BITS'(gi));

`ifdef LLC_SET_BUF_WORD_WRITE_EN
    for (genvar gw = 0; gw < WORDS; gw++) begin : g_word
      assign wr_merged[gw*WORD_BITS +: WORD_BITS] = wr_word_mask[gw] ?
          wr_line[gw*WORD_BITS +: WORD_BITS] : line_reg[gi][gw*WORD_BITS +: WORD_BITS];
    end
`else
    assign wr_merged = wr_line;
`endif

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        line_reg[gi]    <= '0;
        tag_reg[gi]     <= '0;
        state_reg[gi]   <= '0;
        sharers_reg[gi] <= '0;
        owner_reg[gi]   <= '0;
        hprot_reg[gi]   <= '0;
        dirty_reg[gi]   <= 1'b0;
        mod_reg[gi]     <= 1'b0;
      end else if (rst_state) begin
        line_reg[gi]    <= '0;
        tag_reg[gi]     <= '0;
        state_reg[gi]   <= '0;
        sharers_reg[gi] <= '0;
        owner_reg[gi]   <= '0;
        hprot_reg[gi]   <= '0;
        dirty_reg[gi]   <= 1'b0;
        mod_reg[gi]     <= 1'b0;
      end else if (load_hs) begin
        line_reg[gi]    <= ld_line[gi*LINE_BITS +: LINE_BITS];
        tag_reg[gi]     <= ld_tag[gi*TAG_BITS +: TAG_BITS];
        state_reg[gi]   <= ld_state[gi*STATE_BITS +: STATE_BITS];
        sharers_reg[gi] <= ld_sharers[gi*SHARERS_BITS +: SHARERS_BITS];
        owner_reg[gi]   <= ld_owner[gi*OWNER_BITS +: OWNER_BITS];
        hprot_reg[gi]   <= ld_hprot[gi*HPROT_BITS +: HPROT_BITS];
        dirty_reg[gi]   <= ld_dirty[gi];
        mod_reg[gi]     <= 1'b0;
      end else begin
        // The fill owns the line; the other fields of the same way still take their writes.
        if (fill_hit)                line_reg[gi]    <= fill_line;
        else if (wr_hit && wr_en[0]) line_reg[gi]    <= wr_merged;
        if (wr_hit && wr_en[1])      tag_reg[gi]     <= wr_tag;
        if (wr_hit && wr_en[2])      state_reg[gi]   <= wr_state;
        if (wr_hit && wr_en[3])      sharers_reg[gi] <= wr_sharers;
        if (wr_hit && wr_en[4])      owner_reg[gi]   <= wr_owner;
        if (wr_hit && wr_en[5])      hprot_reg[gi]   <= wr_hprot;
        if (wr_hit && wr_en[6])      dirty_reg[gi]   <= wr_dirty;
        if (fill_hit || (wr_hit && (wr_en != 7'd0))) mod_reg[gi] <= 1'b1;
      end
    end
  end

  always_comb begin
    lines    = '0;
    tags     = '0;
    states   = '0;
    sharers  = '0;
    owners   = '0;
    hprots   = '0;
    dirty    = '0;
    mod_mask = '0;
    for (int i = 0; i < WAYS; i++) begin
      lines[i*LINE_BITS +: LINE_BITS]          = line_reg[i];
      tags[i*TAG_BITS +: TAG_BITS]             = tag_reg[i];
      states[i*STATE_BITS +: STATE_BITS]       = state_reg[i];
      sharers[i*SHARERS_BITS +: SHARERS_BITS]  = sharers_reg[i];
      owners[i*OWNER_BITS +: OWNER_BITS]       = owner_reg[i];
      hprots[i*HPROT_BITS +: HPROT_BITS]       = hprot_reg[i];
      dirty[i]                                 = dirty_reg[i];
      mod_mask[i]                              = mod_reg[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evict_reg <= '0;
    end else if (rst_state) begin
      evict_reg <= '0;
    end else if (load_hs) begin
      evict_reg <= ld_evict_way;
    end else if (incr_evict) begin
      evict_reg <= evict_reg + 1'b1;
    end
  end

  // Victim search walks from the eviction pointer, stopping at the first INVALID way.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_reg        <= IDLE;
      k_reg          <= '0;
      victim_valid   <= 1'b0;
      victim_way     <= '0;
      victim_invalid <= 1'b0;
    end else if (rst_state) begin
      fsm_reg        <= IDLE;
      k_reg          <= '0;
      victim_valid   <= 1'b0;
      victim_way     <= '0;
      victim_invalid <= 1'b0;
    end else begin
      case (fsm_reg)
        IDLE: begin
          victim_valid <= 1'b0;
          if (victim_req) begin
            fsm_reg <= SCAN;
            k_reg   <= '0;
          end
        end
        SCAN: begin
          if (state_reg[scan_way] == '0) begin
            victim_way     <= scan_way;
            victim_invalid <= 1'b1;
            victim_valid   <= 1'b1;
            fsm_reg        <= DONE;
          end else if (k_reg == WAY_BITS'(WAYS - 1)) begin
            victim_way     <= evict_reg;
            victim_invalid <= 1'b0;
            victim_valid   <= 1'b1;
            fsm_reg        <= DONE;
          end else begin
            k_reg <= k_reg + 1'b1;
          end
        end
        default: begin
          victim_valid <= 1'b0;
          fsm_reg      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_llc_set_buf.sv
// Randomised bench for llc_set_buf against an array-based model of the set.
module tb_llc_set_buf;
  localparam int WAYS = 16, LB = 128, WORDS = 2, TB = 16, SB = 3, SHB = 16, OB = 4, HB = 1;
  localparam int WW = 4, WDB = LB / WORDS;

  logic clk = 1'b0, rst = 1'b0, rst_state = 1'b0, load_valid = 1'b0, fill_valid = 1'b0;
  logic load_ready, fill_ready, victim_valid, victim_invalid;
  logic [WAYS*LB-1:0] ld_line = '0, lines;
  logic [WAYS*TB-1:0] ld_tag = '0, tags;
  logic [WAYS*SB-1:0] ld_state = '0, states;
  logic [WAYS*SHB-1:0] ld_sharers = '0, sharers;
  logic [WAYS*OB-1:0] ld_owner = '0, owners;
  logic [WAYS*HB-1:0] ld_hprot = '0, hprots;
  logic [WAYS-1:0] ld_dirty = '0, dirty, mod_mask;
  logic [WW-1:0] ld_evict_way = '0, fill_way = '0, wr_way = '0, victim_way, evict_way;
  logic [LB-1:0] fill_line = '0, wr_line = '0;
  logic [6:0] wr_en = '0;
  logic [WORDS-1:0] wr_word_mask = '0;
  logic [TB-1:0] wr_tag = '0;
  logic [SB-1:0] wr_state = '0;
  logic [SHB-1:0] wr_sharers = '0;
  logic [OB-1:0] wr_owner = '0;
  logic [HB-1:0] wr_hprot = '0;
  logic wr_dirty = 1'b0, victim_req = 1'b0, incr_evict = 1'b0;

  llc_set_buf dut (
    .clk(clk), .rst(rst), .rst_state(rst_state), .load_valid(load_valid), .load_ready(load_ready),
    .ld_line(ld_line), .ld_tag(ld_tag), .ld_state(ld_state), .ld_sharers(ld_sharers),
    .ld_owner(ld_owner), .ld_hprot(ld_hprot), .ld_dirty(ld_dirty), .ld_evict_way(ld_evict_way),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_way(fill_way), .fill_line(fill_line),
    .wr_way(wr_way), .wr_en(wr_en), .wr_word_mask(wr_word_mask), .wr_line(wr_line),
    .wr_tag(wr_tag), .wr_state(wr_state), .wr_sharers(wr_sharers), .wr_owner(wr_owner),
    .wr_hprot(wr_hprot), .wr_dirty(wr_dirty), .victim_req(victim_req),
    .victim_valid(victim_valid), .victim_way(victim_way), .victim_invalid(victim_invalid),
    .incr_evict(incr_evict), .evict_way(evict_way), .mod_mask(mod_mask), .lines(lines),
    .tags(tags), .states(states), .sharers(sharers), .owners(owners), .hprots(hprots),
    .dirty(dirty)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model of the set contents
  logic [LB-1:0]  m_line [WAYS];
  logic [TB-1:0]  m_tag [WAYS];
  logic [SB-1:0]  m_state [WAYS];
  logic [SHB-1:0] m_sharers [WAYS];
  logic [OB-1:0]  m_owner [WAYS];
  logic [HB-1:0]  m_hprot [WAYS];
  logic           m_dirty [WAYS];
  logic           m_mod [WAYS];
  int             m_evict;

  task automatic model_clear();
    for (int i = 0; i < WAYS; i++) begin
      m_line[i] = '0; m_tag[i] = '0; m_state[i] = '0; m_sharers[i] = '0;
      m_owner[i] = '0; m_hprot[i] = '0; m_dirty[i] = 1'b0; m_mod[i] = 1'b0;
    end
    m_evict = 0;
  endtask

  // Applies the current inputs to the model as one clock edge would.
  task automatic model_step();
    if (rst_state) model_clear();
    else if (load_valid) begin
      for (int i = 0; i < WAYS; i++) begin
        m_line[i] = ld_line[i*LB +: LB]; m_tag[i] = ld_tag[i*TB +: TB];
        m_state[i] = ld_state[i*SB +: SB]; m_sharers[i] = ld_sharers[i*SHB +: SHB];
        m_owner[i] = ld_owner[i*OB +: OB]; m_hprot[i] = ld_hprot[i*HB +: HB];
        m_dirty[i] = ld_dirty[i]; m_mod[i] = 1'b0;
      end
      m_evict = int'(ld_evict_way);
    end else begin
      for (int i = 0; i < WAYS; i++) begin
        bit fh, wh;
        fh = fill_valid && (int'(fill_way) == i);
        wh = (int'(wr_way) == i);
        if (fh) m_line[i] = fill_line;
        else if (wh && wr_en[0]) begin
`ifdef LLC_SET_BUF_WORD_WRITE_EN
          for (int w = 0; w < WORDS; w++)
            if (wr_word_mask[w]) m_line[i][w*WDB +: WDB] = wr_line[w*WDB +: WDB];
`else
          m_line[i] = wr_line;
`endif
        end
        if (wh && wr_en[1]) m_tag[i] = wr_tag;
        if (wh && wr_en[2]) m_state[i] = wr_state;
        if (wh && wr_en[3]) m_sharers[i] = wr_sharers;
        if (wh && wr_en[4]) m_owner[i] = wr_owner;
        if (wh && wr_en[5]) m_hprot[i] = wr_hprot;
        if (wh && wr_en[6]) m_dirty[i] = wr_dirty;
        if (fh || (wh && wr_en != 7'd0)) m_mod[i] = 1'b1;
      end
      if (incr_evict) m_evict = (m_evict + 1) % WAYS;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    load_valid = 0; fill_valid = 0; wr_en = '0; incr_evict = 0; victim_req = 0; rst_state = 0;
  endtask

  task automatic check_all(input string tag);
    logic [WAYS-1:0] mm;
    for (int i = 0; i < WAYS; i++) begin
      check($sformatf("%s line%0d", tag, i), lines[i*LB +: LB], m_line[i]);
      check($sformatf("%s tag%0d", tag, i), tags[i*TB +: TB], m_tag[i]);
      check($sformatf("%s state%0d", tag, i), states[i*SB +: SB], m_state[i]);
      check($sformatf("%s sharers%0d", tag, i), sharers[i*SHB +: SHB], m_sharers[i]);
      check($sformatf("%s owner%0d", tag, i), owners[i*OB +: OB], m_owner[i]);
      check($sformatf("%s hprot%0d", tag, i), hprots[i*HB +: HB], m_hprot[i]);
      check($sformatf("%s dirty%0d", tag, i), dirty[i], m_dirty[i]);
      mm[i] = m_mod[i];
    end
    check({tag, " mod_mask"}, mod_mask, mm);
    check({tag, " evict_way"}, evict_way, m_evict);
  endtask

  function automatic logic [LB-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic rand_ld();
    for (int i = 0; i < WAYS; i++) begin
      ld_line[i*LB +: LB] = rnd_line();
      ld_tag[i*TB +: TB] = TB'($urandom);
      ld_state[i*SB +: SB] = SB'($urandom_range(1, 7));
      ld_sharers[i*SHB +: SHB] = SHB'($urandom);
      ld_owner[i*OB +: OB] = OB'($urandom);
      ld_hprot[i*HB +: HB] = HB'($urandom);
      ld_dirty[i] = 1'($urandom);
    end
    ld_evict_way = WW'($urandom);
  endtask

  task automatic do_load();
    load_valid = 1; tick(); load_valid = 0;
  endtask

  task automatic run_victim(input string tag);
    int exp_k, exp_n, exp_way, n;
    exp_k = -1; exp_way = m_evict;
    for (int k = 0; k < WAYS; k++) begin
      if (exp_k < 0 && m_state[(m_evict + k) % WAYS] == '0) begin
        exp_k = k; exp_way = (m_evict + k) % WAYS;
      end
    end
    exp_n = (exp_k >= 0) ? exp_k + 2 : WAYS + 1;
    victim_req = 1; tick(); victim_req = 0;
    n = 1;
    check({tag, " busy load_ready"}, load_ready, 1'b0);
    while (!victim_valid && n < 64) begin tick(); n++; end
    check({tag, " latency"}, n, exp_n);
    check({tag, " victim_way"}, victim_way, exp_way);
    check({tag, " victim_invalid"}, victim_invalid, exp_k >= 0);
    tick();
    check({tag, " valid pulse"}, victim_valid, 1'b0);
    check({tag, " way held"}, victim_way, exp_way);
    check({tag, " idle load_ready"}, load_ready, 1'b1);
  endtask

  initial begin
    logic [LB-1:0] old_line, exp_line;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1;
    #1;
    check_all("reset");
    check("reset load_ready", load_ready, 1'b1);
    check("reset fill_ready", fill_ready, 1'b1);
    check("reset victim_valid", victim_valid, 1'b0);
    check("reset victim_way", victim_way, 0);
    check("reset victim_invalid", victim_invalid, 1'b0);

    // Way 0 state 2, way 1 INVALID, others 1; pointer 3
    rand_ld();
    for (int i = 0; i < WAYS; i++) ld_state[i*SB +: SB] = (i == 0) ? 3'd2 : (i == 1) ? 3'd0 : 3'd1;
    ld_evict_way = 4'd3;
    do_load();
    check_all("load1");
    run_victim("vic_inv");
    check("vic_inv way1", victim_way, 4'd1);

    // No invalid way, pointer wraps 15 -> 0
    rand_ld(); ld_evict_way = 4'd15;
    do_load();
    incr_evict = 1; tick(); incr_evict = 0;
    check("wrap evict_way", evict_way, 4'd0);
    run_victim("vic_full");

    // Fill and line write collide on way 5
    rand_ld(); do_load();
    fill_valid = 1; fill_way = 4'd5; fill_line = {16{8'hA5}};
    wr_way = 4'd5; wr_en = 7'h7F; wr_word_mask = 2'b11; wr_line = rnd_line();
    wr_tag = 16'h1234; wr_state = 3'd4; wr_sharers = 16'hBEEF; wr_owner = 4'd9;
    wr_hprot = 1'b1; wr_dirty = 1'b1;
    tick(); quiet();
    check("collide line5", lines[5*LB +: LB], {16{8'hA5}});
    check("collide tag5", tags[5*TB +: TB], 16'h1234);
    check("collide mod_mask", mod_mask, 16'h0020);
    check_all("collide");
    do_load();
    check("reload mod_mask", mod_mask, 16'h0000);

    // Partial-word line write on way 2
    old_line = m_line[2];
    wr_way = 4'd2; wr_en = 7'h01; wr_word_mask = 2'b10; wr_line = rnd_line();
`ifdef LLC_SET_BUF_WORD_WRITE_EN
    exp_line = {wr_line[LB-1:WDB], old_line[WDB-1:0]};
`else
    exp_line = wr_line;
`endif
    tick(); quiet();
    check("word_mask line2", lines[2*LB +: LB], exp_line);
    check("word_mask mod_mask", mod_mask, 16'h0004);

    // rst_state during SCAN at offset 4
    rand_ld(); do_load();
    victim_req = 1; tick(); victim_req = 0;
    repeat (4) tick();
    rst_state = 1;
    #1;
    check("rst_state load_ready", load_ready, 1'b0);
    check("rst_state fill_ready", fill_ready, 1'b0);
    tick(); rst_state = 0;
    #1;
    check("rst_state idle", load_ready, 1'b1);
    check("rst_state no valid", victim_valid, 1'b0);
    check_all("rst_state");
    begin
      int seen = 0;
      for (int c = 0; c < 20; c++) begin tick(); if (victim_valid) seen++; end
      check("rst_state no late valid", seen, 0);
    end

    // Asynchronous reset held across a load edge
    rand_ld(); load_valid = 1;
    #2 rst = 0;
    model_clear();
    @(posedge clk); #1;
    check_all("rst_hold");
    load_valid = 0; rst = 1; #1;
    check_all("rst_release");
    check("rst_release victim_way", victim_way, 0);
    check("rst_release load_ready", load_ready, 1'b1);

    // Randomised load / fill / write / search rounds
    for (int it = 0; it < 25; it++) begin
      rand_ld();
      for (int i = 0; i < WAYS; i++)
        if ($urandom_range(0, 5) == 0) ld_state[i*SB +: SB] = '0;
      do_load();
      for (int c = 0; c < 6; c++) begin
        fill_valid = 1'($urandom); fill_way = WW'($urandom); fill_line = rnd_line();
        wr_way = WW'($urandom); wr_en = ($urandom_range(0, 2) == 0) ? 7'd0 : 7'($urandom);
        wr_word_mask = WORDS'($urandom); wr_line = rnd_line(); wr_tag = TB'($urandom);
        wr_state = SB'($urandom); wr_sharers = SHB'($urandom); wr_owner = OB'($urandom);
        wr_hprot = HB'($urandom); wr_dirty = 1'($urandom);
        incr_evict = ($urandom_range(0, 3) == 0);
        tick(); quiet();
      end
      check_all($sformatf("rnd%0d", it));
      run_victim($sformatf("rnd%0d vic", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
